instr_fetch: RTL

Instruction fetch unit: the consumer side of the program counter. It owns the fetch address, issues in-order read requests to instruction memory with a valid/ready handshake, and buffers returned words with their PCs in a small queue. Decode drains the queue through a valid/ready output. A redirect input (branch/jump) reloads the fetch address and discards all stale work.

---
 rtl/instr_fetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Owns the fetch address, issues in-order word reads
// to instruction memory over a valid/ready request channel, and buffers the
// returned words together with their PCs in a small queue drained by decode.
// A redirect reloads the fetch address, empties the queue, and arranges for
// every response still in flight to be discarded when it arrives.
//
// Parameters
//   RESET_PC     fetch address after reset (word aligned)
//   DEPTH        queue entries == maximum outstanding requests (power of 2, >=2)
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   redirect     reload fetch address from redirect_pc, flush everything
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   req_valid    memory request valid
//   req_ready    memory accepts the request
//   req_addr     requested word address (current fetch PC)
//   rsp_valid    memory returns one word (no backpressure)
//   rsp_data     returned instruction word
//   out_valid    queue head valid toward decode
//   out_ready    decode accepts the head
//   out_instr    head instruction
//   out_pc       address of the head instruction
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  // Pending-address FIFO: PCs of accepted requests, in memory order
  logic [31:0]   pend_addr_q [DEPTH];
  logic [AW-1:0] pend_wr_q, pend_wr_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;

  // Instruction queue toward decode
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   q_instr_q [DEPTH];
  logic [AW-1:0] q_wr_q, q_wr_d;
  logic [AW-1:0] q_rd_q, q_rd_d;

  logic [CW:0]   credits_used;
  logic          req_fire;
  logic          q_push;
  logic          q_pop;
  logic [31:0]   pend_head;

  // Credits count buffered entries plus in-flight requests. A pop in the
  // current cycle is deliberately not credited back until the next cycle so
  // that req_valid has no combinational path from out_ready.
  assign credits_used = {1'b0, count_q} + {1'b0, outst_q};

  // reset is folded in so the request channel is quiet while reset is held,
  // whatever the counters held before it.
  assign req_valid = !reset && !redirect && (credits_used < DEPTH_C);
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;

  assign out_valid = (count_q != '0);
  assign out_pc    = q_pc_q[q_rd_q];
  assign out_instr = q_instr_q[q_rd_q];

  // A redirect voids both the head and any arriving word.
  assign q_pop     = out_valid && out_ready && !redirect;
  assign q_push    = rsp_valid && (drop_q == '0) && !redirect;
  assign pend_head = pend_addr_q[pend_rd_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;

    // The pending FIFO and outstanding count track the memory, which is
    // never flushed: every accepted request yields exactly one response.
    if (req_fire) begin
      pend_wr_d = pend_wr_q + AW'(1);
    end
    if (rsp_valid) begin
      pend_rd_d = pend_rd_q + AW'(1);
    end
    outst_d = outst_q + CW'(req_fire) - CW'(rsp_valid);

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      q_wr_d     = '0;
      q_rd_d     = '0;
      // Everything still in flight after this cycle is stale.
      drop_d     = outst_q - CW'(rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (q_push) begin
        q_wr_d = q_wr_q + AW'(1);
      end
      if (q_pop) begin
        q_rd_d = q_rd_q + AW'(1);
      end
      count_d = count_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
    end
  end

  // Storage is cleared on reset so out_pc/out_instr read as zero afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_addr_q[i] <= '0;
        q_pc_q[i]      <= '0;
        q_instr_q[i]   <= '0;
      end
    end else begin
      if (req_fire) begin
        pend_addr_q[pend_wr_q] <= fetch_pc_q;
      end
      if (q_push) begin
        q_pc_q[q_wr_q]    <= pend_head;
        q_instr_q[q_wr_q] <= rsp_data;
      end
    end
  end

endmodule
